// File: rtl/cond_flag_pkg.sv
// -----------------------------------------------------------------------------
// cond_flag_pkg
// Shared definitions for the condition-flag unit: the {N,Z,C,V} flag word
// type, bit positions inside that word, the 16 condition codes and a helper
// that merges a freshly computed flag word into a stored one under a mask.
// -----------------------------------------------------------------------------
package cond_flag_pkg;

  // Bit positions inside the {N,Z,C,V} flag word
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] flags_t;

  // Condition codes
  localparam logic [3:0] COND_NEVER  = 4'd0;
  localparam logic [3:0] COND_ALWAYS = 4'd1;
  localparam logic [3:0] COND_N      = 4'd2;
  localparam logic [3:0] COND_Z      = 4'd3;
  localparam logic [3:0] COND_NZ     = 4'd4;
  localparam logic [3:0] COND_C      = 4'd5;
  localparam logic [3:0] COND_NC     = 4'd6;
  localparam logic [3:0] COND_V      = 4'd7;
  localparam logic [3:0] COND_NV     = 4'd8;
  localparam logic [3:0] COND_NN     = 4'd9;
  localparam logic [3:0] COND_SLT    = 4'd10;
  localparam logic [3:0] COND_SGE    = 4'd11;
  localparam logic [3:0] COND_SGT    = 4'd12;
  localparam logic [3:0] COND_SLE    = 4'd13;
  localparam logic [3:0] COND_UGT    = 4'd14;
  localparam logic [3:0] COND_ULE    = 4'd15;

  // Bits set in mask take the new value, the rest keep the old value
  function automatic flags_t merge_flags(flags_t old_f, flags_t new_f, logic [3:0] mask);
    return (old_f & ~mask) | (new_f & mask);
  endfunction

endpackage

// File: rtl/cond_eval.sv
// -----------------------------------------------------------------------------
// cond_eval
// Purely combinational decode of a 4-bit condition code against a flag word.
// Ports:
//   flags  in  4  {N,Z,C,V}
//   cond   in  4  condition code (see cond_flag_pkg)
//   take   out 1  condition outcome
// -----------------------------------------------------------------------------
module cond_eval
  import cond_flag_pkg::*;
(
  input  flags_t     flags,
  input  logic [3:0] cond,
  output logic       take
);

  logic n_s, z_s, c_s, v_s;

  assign n_s = flags[FLAG_N];
  assign z_s = flags[FLAG_Z];
  assign c_s = flags[FLAG_C];
  assign v_s = flags[FLAG_V];

  // Condition-code decode
  always_comb begin
    take = 1'b0;
    case (cond)
      COND_NEVER:  take = 1'b0;
      COND_ALWAYS: take = 1'b1;
      COND_N:      take = n_s;
      COND_Z:      take = z_s;
      COND_NZ:     take = ~z_s;
      COND_C:      take = c_s;
      COND_NC:     take = ~c_s;
      COND_V:      take = v_s;
      COND_NV:     take = ~v_s;
      COND_NN:     take = ~n_s;
      COND_SLT:    take = n_s ^ v_s;
      COND_SGE:    take = ~(n_s ^ v_s);
      COND_SGT:    take = ~z_s & ~(n_s ^ v_s);
      COND_SLE:    take = z_s | (n_s ^ v_s);
      COND_UGT:    take = c_s & ~z_s;
      COND_ULE:    take = ~c_s | z_s;
      default:     take = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_flag_unit.sv
// -----------------------------------------------------------------------------
// cond_flag_unit
// Multi-bank {N,Z,C,V} flag store with sticky overflow and a one-cycle,
// valid/ready condition evaluator.
// Optional feature macro: COND_FLAG_BYPASS_EN -- when defined, an evaluation
// accepted in the same cycle as an update to the same bank sees the
// post-update flags (per-bit, honouring upd_mask).
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   upd_valid/bank/mask        flag-update request, target bank, {N,Z,C,V} enables
//   res, carry_in, ovf_in      ALU result and carry/overflow sources
//   sticky_clr                 clear sticky overflow of upd_bank
//   eval_valid/ready/bank/cond evaluation request handshake, bank, condition code
//   take_valid/ready           result handshake
//   take, flags_out            outcome and flag snapshot used for it
//   sticky_v                   per-bank sticky overflow
// -----------------------------------------------------------------------------
module cond_flag_unit
  import cond_flag_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int NBANKS = 2,
  localparam int BW     = (NBANKS > 1) ? $clog2(NBANKS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              upd_valid,
  input  logic [BW-1:0]     upd_bank,
  input  logic [3:0]        upd_mask,
  input  logic [WIDTH-1:0]  res,
  input  logic              carry_in,
  input  logic              ovf_in,
  input  logic              sticky_clr,
  input  logic              eval_valid,
  output logic              eval_ready,
  input  logic [BW-1:0]     eval_bank,
  input  logic [3:0]        cond,
  output logic              take_valid,
  input  logic              take_ready,
  output logic              take,
  output logic [3:0]        flags_out,
  output logic [NBANKS-1:0] sticky_v
);

  logic [NBANKS-1:0][3:0] bank_q, bank_d;
  logic [NBANKS-1:0]      sticky_q, sticky_d;
  logic                   take_valid_q, take_valid_d;
  logic                   take_q, take_d;
  flags_t                 flags_out_q, flags_out_d;

  flags_t upd_flags_s;
  flags_t rd_flags_s;
  flags_t src_flags_s;
  logic   eval_in_range_s;
  logic   byp_hit_s;
  logic   take_s;
  logic   accept_s;

  assign upd_flags_s = {res[WIDTH-1], (res == {WIDTH{1'b0}}), carry_in, ovf_in};

  // Read the addressed bank; an index past NBANKS matches nothing and reads 0
  always_comb begin
    rd_flags_s      = 4'b0000;
    eval_in_range_s = 1'b0;
    for (int b = 0; b < NBANKS; b++) begin
      rd_flags_s      = rd_flags_s | (bank_q[b] & {4{eval_bank == BW'(b)}});
      eval_in_range_s = eval_in_range_s | (eval_bank == BW'(b));
    end
  end

`ifdef COND_FLAG_BYPASS_EN
  assign byp_hit_s = upd_valid & (upd_bank == eval_bank);
`else
  assign byp_hit_s = 1'b0;
`endif

  assign src_flags_s = byp_hit_s ? merge_flags(rd_flags_s, upd_flags_s, upd_mask) : rd_flags_s;

  cond_eval u_cond_eval (
    .flags (src_flags_s),
    .cond  (cond),
    .take  (take_s)
  );

  // A held result blocks new requests until the consumer takes it
  assign eval_ready = ~take_valid_q | take_ready;
  assign accept_s   = eval_valid & eval_ready;

  // Bank flag and sticky-overflow next state; a sticky set beats a same-cycle clear
  always_comb begin
    bank_d   = bank_q;
    sticky_d = sticky_q;
    for (int b = 0; b < NBANKS; b++) begin
      if (upd_valid && (upd_bank == BW'(b))) begin
        bank_d[b] = merge_flags(bank_q[b], upd_flags_s, upd_mask);
      end else begin
        bank_d[b] = bank_q[b];
      end
      if (upd_valid && (upd_bank == BW'(b)) && upd_mask[FLAG_V] && ovf_in) begin
        sticky_d[b] = 1'b1;
      end else if (sticky_clr && (upd_bank == BW'(b))) begin
        sticky_d[b] = 1'b0;
      end else begin
        sticky_d[b] = sticky_q[b];
      end
    end
  end

  // Result register next state: load on accept, drop valid once consumed, else hold
  always_comb begin
    take_valid_d = take_valid_q;
    take_d       = take_q;
    flags_out_d  = flags_out_q;
    if (accept_s) begin
      take_valid_d = 1'b1;
      take_d       = take_s & eval_in_range_s;
      flags_out_d  = eval_in_range_s ? src_flags_s : 4'b0000;
    end else if (take_ready) begin
      take_valid_d = 1'b0;
      take_d       = take_q;
      flags_out_d  = flags_out_q;
    end else begin
      take_valid_d = take_valid_q;
      take_d       = take_q;
      flags_out_d  = flags_out_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q       <= '0;
      sticky_q     <= '0;
      take_valid_q <= 1'b0;
      take_q       <= 1'b0;
      flags_out_q  <= 4'b0000;
    end else begin
      bank_q       <= bank_d;
      sticky_q     <= sticky_d;
      take_valid_q <= take_valid_d;
      take_q       <= take_d;
      flags_out_q  <= flags_out_d;
    end
  end

  assign take_valid = take_valid_q;
  assign take       = take_q;
  assign flags_out  = flags_out_q;
  assign sticky_v   = sticky_q;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Bench for cond_flag_unit: directed scenarios followed by randomized traffic,
// all compared against a behavioural model of the flag banks and result stage.
// NBANKS = 3 so that bank index 3 is out of range.
module tb_cond_flag_unit;

  localparam int W  = 32;
  localparam int NB = 3;
  localparam int BW = 2;
`ifdef COND_FLAG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          upd_valid, carry_in, ovf_in, sticky_clr;
  logic [BW-1:0] upd_bank, eval_bank;
  logic [3:0]    upd_mask, cond, flags_out;
  logic [W-1:0]  res;
  logic          eval_valid, eval_ready, take_valid, take_ready, take;
  logic [NB-1:0] sticky_v;

  always #5 clk = ~clk;

  cond_flag_unit #(.WIDTH(W), .NBANKS(NB)) dut (
    .clk(clk), .rst_n(rst_n),
    .upd_valid(upd_valid), .upd_bank(upd_bank), .upd_mask(upd_mask),
    .res(res), .carry_in(carry_in), .ovf_in(ovf_in), .sticky_clr(sticky_clr),
    .eval_valid(eval_valid), .eval_ready(eval_ready), .eval_bank(eval_bank), .cond(cond),
    .take_valid(take_valid), .take_ready(take_ready), .take(take),
    .flags_out(flags_out), .sticky_v(sticky_v)
  );

  int tests = 0;
  int fails = 0;

  // Model state
  logic [3:0]    m_flags [4];
  logic [NB-1:0] m_sticky;
  logic          m_valid, m_take;
  logic [3:0]    m_fout;
  logic          hold_take;
  logic [3:0]    hold_f;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Condition meaning written in terms of the comparisons each code stands for
  function automatic logic cond_ref(input logic [3:0] f, input logic [3:0] c);
    logic n, z, cy, v, lt;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    lt = (n != v);
    case (c)
      4'd0:    return 1'b0;
      4'd1:    return 1'b1;
      4'd2:    return n;
      4'd3:    return z;
      4'd4:    return !z;
      4'd5:    return cy;
      4'd6:    return !cy;
      4'd7:    return v;
      4'd8:    return !v;
      4'd9:    return !n;
      4'd10:   return lt;
      4'd11:   return !lt;
      4'd12:   return !lt && !z;
      4'd13:   return lt || z;
      4'd14:   return cy && !z;
      default: return !cy || z;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_flags[i] = 4'b0000;
    m_sticky = '0;
    m_valid  = 1'b0;
    m_take   = 1'b0;
    m_fout   = 4'b0000;
  endtask

  task automatic idle();
    upd_valid = 1'b0; upd_bank = 2'd0; upd_mask = 4'b0000; res = 32'd0;
    carry_in = 1'b0; ovf_in = 1'b0; sticky_clr = 1'b0;
    eval_valid = 1'b0; eval_bank = 2'd0; cond = 4'd0; take_ready = 1'b1;
  endtask

  // One clock: check outputs mid-cycle, advance model, commit just after the edge
  task automatic cycle();
    logic       acc, n_valid, n_take, in_rng;
    logic [3:0] newf, merged, src, n_f;
    @(negedge clk);
    chk("take_valid", 64'(take_valid), 64'(m_valid));
    chk("take", 64'(take), 64'(m_take));
    chk("flags_out", 64'(flags_out), 64'(m_fout));
    chk("sticky_v", 64'(sticky_v), 64'(m_sticky));
    chk("eval_ready", 64'(eval_ready), 64'(!m_valid || take_ready));
    newf   = {($signed(res) < 0), (res == 32'd0), carry_in, ovf_in};
    merged = m_flags[upd_bank];
    for (int i = 0; i < 4; i++) if (upd_mask[i]) merged[i] = newf[i];
    acc     = eval_valid && (!m_valid || take_ready);
    n_valid = m_valid; n_take = m_take; n_f = m_fout;
    if (acc) begin
      in_rng = (int'(eval_bank) < NB);
      src = m_flags[eval_bank];
      if (BYP && upd_valid && upd_bank == eval_bank) src = merged;
      n_valid = 1'b1;
      n_take  = in_rng ? cond_ref(src, cond) : 1'b0;
      n_f     = in_rng ? src : 4'b0000;
    end else if (take_ready) begin
      n_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    m_valid = n_valid; m_take = n_take; m_fout = n_f;
    if (upd_valid && int'(upd_bank) < NB) begin
      m_flags[upd_bank] = merged;
      if (upd_mask[0] && ovf_in) m_sticky[upd_bank] = 1'b1;
      else if (sticky_clr) m_sticky[upd_bank] = 1'b0;
    end else if (sticky_clr && int'(upd_bank) < NB) begin
      m_sticky[upd_bank] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_take_valid", 64'(take_valid), 64'd0);
    chk("rst_take", 64'(take), 64'd0);
    chk("rst_flags_out", 64'(flags_out), 64'd0);
    chk("rst_sticky", 64'(sticky_v), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Negative result sets N
    upd_valid = 1'b1; upd_bank = 2'd0; upd_mask = 4'b1111; res = 32'hFFFF_FFF0;
    cycle();
    idle(); eval_valid = 1'b1; eval_bank = 2'd0; cond = 4'd2;
    cycle();
    chk("neg_take", 64'(take), 64'd1);
    chk("neg_flags", 64'(flags_out), 64'b1000);

    // Bank independence
    idle(); upd_valid = 1'b1; upd_bank = 2'd1; upd_mask = 4'b0100; res = 32'd0;
    cycle();
    idle(); eval_valid = 1'b1; eval_bank = 2'd1; cond = 4'd3;
    cycle();
    chk("bank1_z", 64'(take), 64'd1);
    eval_bank = 2'd0;
    cycle();
    chk("bank0_z", 64'(take), 64'd0);

    // Same-cycle update and evaluation on one bank
    idle(); upd_valid = 1'b1; upd_bank = 2'd0; upd_mask = 4'b0100; res = 32'd0;
    eval_valid = 1'b1; eval_bank = 2'd0; cond = 4'd3;
    cycle();
    chk("bypass_take", 64'(take), 64'(BYP));

    // Output stall with an update underneath
    idle(); eval_valid = 1'b1; eval_bank = 2'd0; cond = 4'd14;
    cycle();
    hold_take = m_take; hold_f = m_fout;
    take_ready = 1'b0; cond = 4'd1;
    upd_valid = 1'b1; upd_mask = 4'b1111; res = 32'h0000_0005; carry_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_valid", 64'(take_valid), 64'd1);
      chk("stall_take", 64'(take), 64'(hold_take));
      chk("stall_flags", 64'(flags_out), 64'(hold_f));
      chk("stall_ready", 64'(eval_ready), 64'd0);
    end
    upd_valid = 1'b0; take_ready = 1'b1;
    #1 chk("unstall_ready", 64'(eval_ready), 64'd1);
    cycle();
    chk("unstall_valid", 64'(take_valid), 64'd1);
    chk("unstall_take", 64'(take), 64'd1);

    // Sticky overflow
    idle(); upd_valid = 1'b1; upd_mask = 4'b0001; ovf_in = 1'b1;
    cycle();
    chk("sticky_set", 64'(sticky_v[0]), 64'd1);
    ovf_in = 1'b0;
    cycle();
    chk("sticky_keep", 64'(sticky_v[0]), 64'd1);
    idle(); sticky_clr = 1'b1;
    cycle();
    chk("sticky_clr", 64'(sticky_v[0]), 64'd0);

    // Out-of-range bank
    idle(); upd_valid = 1'b1; upd_bank = 2'd3; upd_mask = 4'b1111; res = 32'd0;
    carry_in = 1'b1; ovf_in = 1'b1; eval_valid = 1'b1; eval_bank = 2'd3; cond = 4'd1;
    cycle();
    chk("oor_take", 64'(take), 64'd0);
    chk("oor_flags", 64'(flags_out), 64'd0);
    chk("oor_sticky", 64'(sticky_v), 64'(m_sticky));

    // Randomized traffic
    for (int k = 0; k < 500; k++) begin
      upd_valid  = ($urandom_range(0, 1) == 1);
      upd_bank   = 2'($urandom_range(0, 3));
      upd_mask   = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       res = 32'd0;
        1:       res = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
        default: res = $urandom;
      endcase
      carry_in   = ($urandom_range(0, 1) == 1);
      ovf_in     = ($urandom_range(0, 3) == 0);
      sticky_clr = ($urandom_range(0, 7) == 0);
      eval_valid = ($urandom_range(0, 3) != 0);
      eval_bank  = 2'($urandom_range(0, 3));
      cond       = 4'($urandom_range(0, 15));
      take_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // Reset while a result is stalled
    idle(); eval_valid = 1'b1; cond = 4'd1;
    cycle();
    idle(); take_ready = 1'b0;
    cycle();
    chk("pre_rst_valid", 64'(take_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(take_valid), 64'd0);
    chk("mid_rst_take", 64'(take), 64'd0);
    chk("mid_rst_flags", 64'(flags_out), 64'd0);
    chk("mid_rst_sticky", 64'(sticky_v), 64'd0);
    model_reset();
    rst_n = 1'b1;
    eval_valid = 1'b1; eval_bank = 2'd0; cond = 4'd1; take_ready = 1'b0;
    cycle();
    chk("post_rst_valid", 64'(take_valid), 64'd1);
    chk("post_rst_take", 64'(take), 64'd1);
    chk("post_rst_flags", 64'(flags_out), 64'd0);
    idle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cond_flag_unit.md
COND_FLAG_UNIT -- requirements
Module: cond_flag_unit

Interface
REQ-001 Parameter WIDTH, default 32: signed ALU result width; legal range 8..64.
REQ-002 Parameter NBANKS, default 2: independent flag banks (one per context); legal range 1..8; BW = max(1, clog2(NBANKS)).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 upd_valid  in  1  flag-update request this cycle.
REQ-006 upd_bank  in  BW  bank written by the update.
REQ-007 upd_mask  in  4  per-flag write enables {N,Z,C,V}, bit3 = N.
REQ-008 res  in  WIDTH  signed ALU result.
REQ-009 carry_in  in  1  ALU carry-out; ovf_in  in  1  ALU signed overflow.
REQ-010 sticky_clr  in  1  clears the sticky-overflow bit of upd_bank.
REQ-011 eval_valid  in  1  condition-evaluation request; eval_ready  out  1  request accepted when valid and ready are both 1.
REQ-012 eval_bank  in  BW  bank read; cond  in  4  condition code.
REQ-013 take_valid  out  1  result valid; take_ready  in  1  consumer accepts.
REQ-014 take  out  1  condition outcome; flags_out  out  4  {N,Z,C,V} snapshot used for the evaluation; sticky_v  out  NBANKS  per-bank sticky overflow.

Function
- REQ-015 Update: on upd_valid, bank upd_bank loads N = res[WIDTH-1], Z = (res == 0), C = carry_in, V = ovf_in, each only where its upd_mask bit is 1; the other flags hold.
- REQ-016 Sticky overflow: sticky_v[b] is set by an update writing V = 1 to bank b; sticky_clr clears it; same-cycle set and clear on one bank leaves it set.
- REQ-017 Conditions: 0 never, 1 always, 2 N, 3 Z, 4 !Z, 5 C, 6 !C, 7 V, 8 !V, 9 !N, 10 N^V (signed lt), 11 !(N^V) (signed ge), 12 !Z & !(N^V) (signed gt), 13 Z | (N^V) (signed le), 14 C & !Z (unsigned gt), 15 !C | Z (unsigned le).
- REQ-018 Latency: an accepted evaluation drives take_valid, take and flags_out exactly one cycle after acceptance.
- REQ-019 Handshake: eval_ready = !take_valid | take_ready; when take_valid = 1 and take_ready = 0, take and flags_out hold stable and no new request is accepted.
- REQ-020 Back-to-back: with take_ready held at 1, one evaluation is accepted every cycle at full throughput.
- REQ-021 take_valid drops to 0 the cycle after take_ready = 1 when no new evaluation is accepted.
- REQ-022 Updates are never stalled; an update during output stall does not change held outputs.
- REQ-023 An out-of-range bank index (>= NBANKS) makes the update a no-op and an evaluation return take = 0, flags_out = 0.

Reset
- REQ-024 Reset asserted: all bank flags = 0, sticky_v = 0, take_valid = 0, take = 0, flags_out = 0, immediately and independent of clk.
- REQ-025 Reset asserted mid-stall discards the pending result; the first edge after release accepts a new request.

Configuration
- REQ-026 Macro COND_FLAG_BYPASS_EN defined: an evaluation accepted in the same cycle as an update to the same bank sees the post-update flags (per-bit forwarding respecting upd_mask).
- REQ-027 Macro COND_FLAG_BYPASS_EN undefined: that evaluation sees pre-update flags; updates to other banks never affect it in either build.

Structure
- REQ-028 Package cond_flag_pkg holds condition-code constants, the {N,Z,C,V} bit-index constants and the flags typedef.
- REQ-029 Condition decode is a combinational sub-module cond_eval (flags, cond -> take), instantiated once.

Verification
- REQ-030 WIDTH=32: update bank0 mask 1111, res=0xFFFFFFF0, carry=0, ovf=0; eval cond 2 next cycle -> take=1, flags_out=1000.
- REQ-031 Update bank1 res=0 mask 0100 then eval bank1 cond 3 -> take=1; eval bank0 cond 3 -> take=0 (banks independent).
- REQ-032 Same-cycle update bank0 res=0 mask 0100 and eval bank0 cond 3 -> take=1 with COND_FLAG_BYPASS_EN, take=0 without.
- REQ-033 Eval cond 14 accepted, take_ready=0 for 3 cycles -> take_valid=1, outputs stable, eval_ready=0; take_ready=1 -> next request accepted that cycle.
- REQ-034 Update ovf=1 mask 0001 -> sticky_v[0]=1; later update V=0 keeps it 1; sticky_clr -> 0.
- REQ-035 rst_n low while take_valid=1 stalled -> take_valid=0 and all flags 0 before next clk edge.
